// File: rtl/mul4_seq_pkg.sv
// -----------------------------------------------------------------------------
// mul4_seq_pkg
// Shared definitions for the sequential multiplier and the datapath blocks that
// follow it.
//   state_t    : FSM state encoding (IDLE, CALC, DONE) in 2 bits
//   ADD_SLICE  : bit width of one add4 ripple slice
//   cnt_width  : iteration-counter width for a given operand width (min 1)
// -----------------------------------------------------------------------------
package mul4_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADD_SLICE = 4;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/add4.sv
// -----------------------------------------------------------------------------
// add4
// 4-bit ripple-carry adder, the datapath adder slice used by mul4_seq.
// Ports:
//   a, b  in  [3:0]  addends
//   ci    in         carry in
//   sum   out [3:0]  a + b + ci, low 4 bits
//   co    out        carry out
// -----------------------------------------------------------------------------
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co
);

    always_comb begin
        logic c;
        // NOTE: every output of a combinational block gets a value on every
        // path before anything else, otherwise synthesis infers a latch.
        sum = '0;
        c   = ci;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/mul4_seq.sv
// -----------------------------------------------------------------------------
// mul4_seq
// Sequential shift-and-add unsigned multiplier. One partial product is added
// per clock through a chain of add4 slices; WIDTH iterations produce a
// 2*WIDTH-bit product.
// Ports:
//   clk    in            rising-edge clock
//   rst_n  in            synchronous active-low reset
//   start  in            request, accepted only in IDLE or DONE
//   a      in  [W-1:0]   multiplicand, captured on the accepting edge
//   b      in  [W-1:0]   multiplier, captured on the accepting edge
//   busy   out           high while iterating (CALC)
//   done   out           one-cycle pulse, p valid in this cycle
//   p      out [2W-1:0]  product, held until the next completion
// -----------------------------------------------------------------------------
module mul4_seq
    import mul4_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N_SLICE = WIDTH / ADD_SLICE;
    localparam int CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (WIDTH < ADD_SLICE || (WIDTH % ADD_SLICE) != 0) begin : g_bad_width
        $error("mul4_seq: WIDTH must be a positive multiple of 4");
    end

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               iter_carry;
    logic [2*WIDTH-1:0] next_accmq;

    assign addend = mq[0] ? mcand : '0;

    // Ripple chain of add4 slices; each slice's carry feeds the next one.
    for (genvar g = 0; g < N_SLICE; g++) begin : g_stage
        logic ci_g;
        logic co_g;

        if (g == 0) begin : g_first
            assign ci_g = 1'b0;
        end else begin : g_chain
            assign ci_g = g_stage[g-1].co_g;
        end

        add4 u_add4 (
            .a   (acc[ADD_SLICE*g +: ADD_SLICE]),
            .b   (addend[ADD_SLICE*g +: ADD_SLICE]),
            .ci  (ci_g),
            .sum (sum[ADD_SLICE*g +: ADD_SLICE]),
            .co  (co_g)
        );
    end

    assign iter_carry = g_stage[N_SLICE-1].co_g;

    // {co,sum,mq} >> 1: the carry re-enters at the top of acc and the consumed
    // multiplier bit falls off the bottom of mq.
    assign next_accmq = {iter_carry, sum, mq[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples its inputs from the same pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            mq    <= '0;
            mcand <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand <= a;
                        mq    <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    {acc, mq} <= next_accmq;
                    cnt       <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        p     <= next_accmq;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule
